// File: rtl/onehot_tx_pkg.sv
// ---------------------------------------------------------------------------
// onehot_tx_pkg
//
// Shared definitions for the serial one-hot frame transmitter:
//   W            frame width in bits (fixed at 8 in this revision)
//   IDX_W        bit-position index width, log2(W)
//   tx_state_e   transmitter FSM states (IDLE, SHIFT, PARITY)
//   onehot_word  builds the frame word from a position index and zero flag
//
// The PARITY state only becomes reachable when the top level is built with
// ONEHOT_TX_PARITY_EN defined; the encoding is kept here unconditionally so
// both builds share one state type.
// ---------------------------------------------------------------------------
package onehot_tx_pkg;

    localparam int W     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_e;

    // Word with only bit 'idx' set, or all zeros when 'zero' is asserted
    // (the index is then ignored).
    function automatic logic [W-1:0] onehot_word(
        input logic [IDX_W-1:0] idx,
        input logic             zero
    );
        logic [W-1:0] word;
        word = '0;
        if (!zero) begin
            word[idx] = 1'b1;
        end
        return word;
    endfunction

endpackage : onehot_tx_pkg

// File: rtl/onehot_piso.sv
// ---------------------------------------------------------------------------
// onehot_piso
//
// W-bit parallel-in / serial-out shift register, MSB first.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset, clears the register
//   load    in   capture d (has priority over shift)
//   shift   in   shift left by one, zero fill
//   d       in   W-bit parallel load value
//   q_msb   out  current most-significant bit (the serial output)
// ---------------------------------------------------------------------------
module onehot_piso
    import onehot_tx_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q_msb
);

    logic [W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift) begin
            sreg <= {sreg[W-2:0], 1'b0};
        end
    end

    assign q_msb = sreg[W-1];

endmodule : onehot_piso

// File: rtl/onehot_tx.sv
// ---------------------------------------------------------------------------
// onehot_tx
//
// Serial one-hot frame transmitter. Accepts a bit-position index through a
// valid/ready handshake, builds the matching one-hot word (or the all-zero
// word) and streams it MSB-first, one bit per clock.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   index request present
//   in_ready   out  request can be accepted this cycle (high only in IDLE)
//   in_idx     in   bit position to set (bit 7 = MSB)
//   in_zero    in   send the all-zero word, in_idx ignored
//   out_valid  out  out_bit carries a frame bit this cycle
//   out_bit    out  serial frame data, MSB first
//   out_last   out  final bit of the frame
//   out_word   out  parallel copy of the frame, held until the next request
//
// Build option:
//   ONEHOT_TX_PARITY_EN  when defined, each frame is followed by one even-
//                        parity bit (9-bit frame, out_last on the parity bit).
//                        When undefined, frames are 8 bits.
//
// Frame timing: a request accepted at edge k puts bit 7 on out_bit in cycle
// k+1 and bit 0 in cycle k+8; in_ready returns in k+9 (k+10 with parity).
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module onehot_tx
    import onehot_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_zero,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic [W-1:0]     out_word
);

`ifdef ONEHOT_TX_PARITY_EN
    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [W-1:0] word);
        return ^word;
    endfunction
`endif

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [IDX_W-1:0] bit_cnt;
    logic [W-1:0]     word_reg;
    logic             accept;
    logic             piso_shift;
    logic             piso_msb;
    logic             cnt_done;

    // Handshake is qualified by registered state only, so in_ready never
    // depends combinationally on in_valid.
    assign accept     = in_valid && (state == IDLE);
    assign piso_shift = (state == SHIFT);
    assign cnt_done   = (bit_cnt == IDX_W'(W - 1));

    // ---- shift register --------------------------------------------------
    onehot_piso u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (piso_shift),
        .d     (onehot_word(in_idx, in_zero)),
        .q_msb (piso_msb)
    );

    // ---- state register --------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_done) begin
`ifdef ONEHOT_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            PARITY: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- bit counter and frame word --------------------------------------
    // The counter wraps 7 -> 0 on the same edge that leaves SHIFT; its value
    // is not looked at again until the next accepted request clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_reg <= '0;
        end else if (accept) begin
            word_reg <= onehot_word(in_idx, in_zero);
        end
    end

    // ---- output decode ---------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_bit   = piso_msb;
`ifdef ONEHOT_TX_PARITY_EN
                out_last  = 1'b0;
`else
                out_last  = cnt_done;
`endif
            end
            PARITY: begin
`ifdef ONEHOT_TX_PARITY_EN
                out_valid = 1'b1;
                out_bit   = even_parity(word_reg);
                out_last  = 1'b1;
`endif
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign out_word = word_reg;

endmodule : onehot_tx

// File: doc/onehot_tx.md
# onehot_tx

Serial one-hot frame transmitter: accepts a 3-bit bit-position index through a valid/ready handshake and serialises the matching 8-bit one-hot word MSB-first, one bit per clock. It is the generating end of the finder path, where a word is reduced to a 3-bit position. This block builds the word from the position and streams it to a downstream receiver or finder stage. It also sources directed stimulus for the finder bench.

## Interface
- `W`, 8, frame width in bits; fixed at 8 for this revision.
- `IDX_W`, 3, index width; equals log2(W).

- `clk` input 1 — single clock; all state updates on rising edge.
- `rst_n` input 1 — synchronous, active-low reset, sampled on rising edge of `clk`.
- `in_valid` input 1 — index request present.
- `in_ready` output 1 — block can accept a request this cycle.
- `in_idx` input IDX_W — bit position to set; bit 7 = MSB.
- `in_zero` input 1 — send the all-zero word; `in_idx` is ignored.
- `out_valid` output 1 — `out_bit` is a valid frame bit this cycle.
- `out_bit` output 1 — serial data, MSB-first.
- `out_last` output 1 — marks the final bit of the frame.
- `out_word` output W — parallel copy of the frame in flight; holds its value after the frame ends.

## Operation
- States are IDLE, SHIFT and (with the macro) PARITY.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`:
    - load the shift register and `out_word` with `in_zero ? 8'h00 : (8'h01 << in_idx)`;
    - clear the bit counter;
    - go to SHIFT.
- SHIFT:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_bit` = shift register bit 7.
  - Each cycle, shift left by one (zero fill) and increment the 3-bit counter.
  - `out_last` = 1 when the counter is 7 (macro off). After that cycle, go to IDLE.
- Requests arriving while not in IDLE are not accepted. The sender must hold `in_valid` and `in_idx` stable until it sees `in_ready`.
- Counter wrap: 3-bit counter, 7 to 0, coincides with leaving SHIFT. The counter is not otherwise used after wrap.
- `out_word` changes only on an accepted request.

## Timing
- Reset (`rst_n` = 0 at an edge): the next cycle shows:
  - state IDLE;
  - `in_ready` = 1;
  - `out_valid`, `out_bit`, `out_last` = 0;
  - `out_word` = 0;
  - counter = 0.
- Reset mid-frame discards the frame; there is no partial completion.
- Reset wins over a simultaneous handshake.
- Request accepted at edge k: first bit (bit 7) is valid in cycle k+1; bit 0 is in cycle k+8, with `out_last` = 1.
- `in_ready` returns to 1 in cycle k+9. Minimum frame-to-frame period is 9 cycles (macro off), including one idle cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `ONEHOT_TX_PARITY_EN`.
- Defined:
  - After bit 0, enter PARITY for one cycle: `out_valid` = 1, `out_bit` = even parity of `out_word` (1 for one-hot, 0 for zero word), `out_last` = 1.
  - `out_last` is not asserted on bit 0.
  - Frame is 9 bits; `in_ready` returns in cycle k+10.
- Undefined: no PARITY state; 8-bit frames as above.

## Structure
- `onehot_tx_pkg` holds:
  - `W` and `IDX_W` constants;
  - the state enum (IDLE, SHIFT, PARITY);
  - a `onehot_word` function (index and zero flag in, word out).
- One sub-module, `onehot_piso`: an 8-bit parallel-in serial-out shift register with `load`, `shift`, `d[7:0]` and `q_msb`.
- FSM, counter and parity logic stay in `onehot_tx`.

## Test plan
- Reset, then idle 3 cycles: `in_ready` = 1, all other outputs 0, `out_word` = 0.
- `in_idx` = 3, single request: `out_word` = 8'b0000_1000. Serial stream is 0,0,0,0,1,0,0,0 in cycles k+1..k+8; `out_last` only at k+8.
- `in_idx` = 7, then `in_zero` = 1, with `in_valid` held high throughout:
  - first stream is 1 then seven 0s;
  - second request is accepted at k+9 and streams eight 0s.
- `rst_n` low at bit 4 of an `in_idx` = 0 frame: next cycle shows `out_valid` = 0, `in_ready` = 1, `out_word` = 0. No `out_last` is seen.
- `in_idx` changed while busy: ignored; the frame in flight is unchanged.
- With `ONEHOT_TX_PARITY_EN` and `in_idx` = 5: 9-bit stream 0,0,1,0,0,0,0,0,1; `out_last` only on the 9th bit; `in_ready` returns at k+10.
